// File: rtl/cdc_hs_rx.sv
// Destination side of a 4-phase req/ack bundled-data crossing.
// Each captured source word becomes exactly one valid/ready stream beat.
module cdc_hs_rx #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_sync,
  input  logic [DW-1:0] data_async,
  output logic          ack,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t          state, state_nxt;
  logic            accept, beat;
  logic            m_valid_nxt;
  logic [DW-1:0]   m_data_nxt;
  logic [CW-1:0]   xfer_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept)    state_nxt = WAIT_LOW;
      WAIT_LOW: if (!req_sync) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // A full buffer only accepts when its current word leaves this very cycle,
  // which gives back-to-back beats without a bubble.
  always_comb begin
    accept       = (state == IDLE) && req_sync && (!m_valid || m_ready);
    beat         = m_valid && m_ready;
    m_valid_nxt  = m_valid;
    m_data_nxt   = m_data;
    xfer_cnt_nxt = xfer_cnt;
    if (beat) m_valid_nxt = 1'b0;
    if (accept) begin
      m_valid_nxt  = 1'b1;
      m_data_nxt   = data_async;
      xfer_cnt_nxt = xfer_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      xfer_cnt <= '0;
    end else begin
      m_valid  <= m_valid_nxt;
      m_data   <= m_data_nxt;
      xfer_cnt <= xfer_cnt_nxt;
    end
  end

  // ack is the WAIT_LOW state flop itself, so it rises with the data capture.
  assign ack  = (state == WAIT_LOW);
  assign busy = (state != IDLE) || m_valid;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Scoreboard bench for cdc_hs_rx: driven words queue up, stream beats pop them.
// A second instance with a 2-bit counter shares the stimulus for the wrap case.
module tb_cdc_hs_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_sync;
  logic [DW-1:0] data_async;
  logic          m_ready;
  logic          ack, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_cnt;
  logic          ack_w, m_valid_w, busy_w;
  logic [DW-1:0] m_data_w;
  logic [1:0]    xfer_cnt_w;

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [DW-1:0] sb_q[$];
  int unsigned   exp_cnt = 0;

  cdc_hs_rx #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_sync(req_sync), .data_async(data_async),
    .ack(ack), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  cdc_hs_rx #(.DW(DW), .CW(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_sync(req_sync), .data_async(data_async),
    .ack(ack_w), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
    .busy(busy_w), .xfer_cnt(xfer_cnt_w)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beats are sampled mid-cycle; the transfer completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) check_eq("extra_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
      else                  check_eq("beat_data", {24'd0, m_data}, {24'd0, sb_q.pop_front()});
    end
  end

  task automatic wait_ack(input logic lvl, input string tag);
    int unsigned n = 0;
    while (ack !== lvl && n < 100) begin
      tick();
      n++;
    end
    if (ack !== lvl) check_eq(tag, {31'd0, ack}, {31'd0, lvl});
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_ack(1'b0, "ack_idle_timeout");
    data_async = d;
    req_sync   = 1'b1;
    sb_q.push_back(d);
    exp_cnt++;
    wait_ack(1'b1, "ack_rise_timeout");
    req_sync = 1'b0;
    wait_ack(1'b0, "ack_fall_timeout");
  endtask

  task automatic do_reset();
    req_sync   = 1'b0;
    data_async = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    sb_q.delete();
    exp_cnt = 0;
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("sb_drained", sb_q.size(), 0);
  endtask

  int unsigned wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    m_ready = 1'b1;
    do_reset();
    check_eq("rst_ack", {31'd0, ack}, 0);
    check_eq("rst_valid", {31'd0, m_valid}, 0);
    check_eq("rst_data", {24'd0, m_data}, 0);
    check_eq("rst_cnt", {16'd0, xfer_cnt}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);

    // Single transfer with cycle-exact latency
    data_async = 8'hA5;
    req_sync   = 1'b1;
    sb_q.push_back(8'hA5);
    exp_cnt++;
    tick();
    check_eq("single_ack", {31'd0, ack}, 1);
    check_eq("single_valid", {31'd0, m_valid}, 1);
    check_eq("single_data", {24'd0, m_data}, 32'hA5);
    check_eq("single_cnt", {16'd0, xfer_cnt}, 1);
    check_eq("single_busy", {31'd0, busy}, 1);
    req_sync = 1'b0;
    tick();
    check_eq("single_ack_fall", {31'd0, ack}, 0);
    check_eq("single_valid_fall", {31'd0, m_valid}, 0);
    check_eq("single_busy_fall", {31'd0, busy}, 0);

    // Backpressure: second word stalls until the first leaves
    do_reset();
    m_ready = 1'b0;
    send(8'h11);
    data_async = 8'h22;
    req_sync   = 1'b1;
    sb_q.push_back(8'h22);
    exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_ack_low", {31'd0, ack}, 0);
      check_eq("bp_data_hold", {24'd0, m_data}, 32'h11);
    end
    m_ready = 1'b1;
    tick();
    check_eq("bp_valid", {31'd0, m_valid}, 1);
    check_eq("bp_data_new", {24'd0, m_data}, 32'h22);
    check_eq("bp_ack", {31'd0, ack}, 1);
    req_sync = 1'b0;
    wait_ack(1'b0, "bp_ack_fall_timeout");
    drain();
    check_eq("bp_cnt", {16'd0, xfer_cnt}, exp_cnt);

    // Back-to-back words at the fastest handshake rate
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i));
    drain();
    check_eq("b2b_cnt", {16'd0, xfer_cnt}, 4);

    // Source data changes during WAIT_LOW must not disturb the captured word
    m_ready    = 1'b0;
    data_async = 8'h3C;
    req_sync   = 1'b1;
    sb_q.push_back(8'h3C);
    exp_cnt++;
    wait_ack(1'b1, "imm_ack_timeout");
    data_async = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("imm_data_hold", {24'd0, m_data}, 32'h3C);
    end
    req_sync = 1'b0;
    wait_ack(1'b0, "imm_ack_fall_timeout");
    m_ready = 1'b1;
    drain();
    for (int i = 0; i < 4; i++) tick();
    check_eq("imm_no_extra", {31'd0, m_valid}, 0);
    check_eq("imm_cnt", {16'd0, xfer_cnt}, exp_cnt);

    // Reset mid-transfer, then a held req is taken as a fresh transfer
    m_ready    = 1'b0;
    data_async = 8'h77;
    req_sync   = 1'b1;
    sb_q.push_back(8'h77);
    wait_ack(1'b1, "mid_ack_timeout");
    check_eq("mid_valid_pre", {31'd0, m_valid}, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ack", {31'd0, ack}, 0);
    check_eq("mid_rst_valid", {31'd0, m_valid}, 0);
    check_eq("mid_rst_cnt", {16'd0, xfer_cnt}, 0);
    sb_q.delete();
    data_async = 8'h5A;
    tick();
    rst_n = 1'b1;
    sb_q.push_back(8'h5A);
    exp_cnt = 1;
    tick();
    check_eq("mid_new_data", {24'd0, m_data}, 32'h5A);
    check_eq("mid_new_ack", {31'd0, ack}, 1);
    req_sync = 1'b0;
    m_ready  = 1'b1;
    wait_ack(1'b0, "mid_ack_fall_timeout");
    drain();

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int unsigned i = 0; i < 5; i++) begin
      send(8'(8'h40 + i));
      check_eq("wrap_cnt", {30'd0, xfer_cnt_w}, wrap_exp[i]);
      check_eq("wide_cnt", {16'd0, xfer_cnt}, exp_cnt);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_hs_rx.md
Name: cdc_hs_rx

Overview:
- Destination-side receiver of a 4-phase req/ack bundled-data clock-domain crossing.
- Consumes the source `req` after it has passed through the synchronizer stage in the `clk` domain.
- Captures the source data bus, which is held stable while `req` is high, and returns `ack` for resynchronization into the source domain.
- Presents each captured word on a valid/ready stream, so one source word produces exactly one stream beat.

Parameters:
- DW, 8, width of transferred data word.
- CW, 16, width of completed-transfer counter.

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low, named as in the rest of the codebase.
- req_sync  input  1  source req, already synchronized to clk.
- data_async  input  DW  source data bus, stable while source req is high.
- ack  output  1  acknowledge to source; registered.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DW  stream data; registered.
- busy  output  1  high when state is not IDLE or m_valid is high.
- xfer_cnt  output  CW  count of accepted words; wraps.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state=IDLE, ack=0, m_valid=0, m_data=0, xfer_cnt=0.
  - busy follows the reset state, so it reads 0.
- State IDLE (ack=0):
  - Define `accept` = req_sync & (~m_valid | m_ready).
  - On accept: m_data<=data_async, m_valid<=1, ack<=1, xfer_cnt<=xfer_cnt+1 (mod 2^CW), state<=WAIT_LOW.
  - If req_sync=1 but the buffer is full and m_ready=0: stall. ack stays 0, data is not sampled, state stays IDLE. This is the backpressure path to the source.
- State WAIT_LOW (ack=1):
  - Hold until req_sync=0.
  - On req_sync=0: ack<=0, state<=IDLE.
  - data_async is ignored while in this state.
- Stream handshake:
  - A beat transfers when m_valid & m_ready.
  - m_valid clears after a beat, unless an accept happens in the same cycle.
  - Simultaneous beat and accept: m_data loads the new word and m_valid stays 1 (back-to-back, no bubble).
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a beat.
- Latency:
  - req_sync sampled high at edge t with the buffer free → m_valid=1, ack=1 and m_data valid after edge t.
  - req_sync sampled low at edge u in WAIT_LOW → ack=0 after edge u.
  - Earliest next accept is edge u+1, so a minimum of 2 clk cycles per transfer on the destination side.
- Ordering: ack rises only in the same cycle data is captured. The source may therefore change data_async once it sees ack.
- req_sync timing: req_sync may arrive one cycle early or late relative to nominal due to synchronizer metastability emulation. It is a level and is monotonic per phase, and the block is insensitive to that skew.
- Reset mid-operation:
  - Reset forces IDLE and ack=0, and drops any buffered word.
  - If req_sync is still 1 after reset release, it is treated as a new transfer and accepted on the first edge with the buffer free.
- Counter: xfer_cnt counts accepts, not stream beats, and wraps from 2^CW-1 to 0.

Test Plan:
- Single transfer:
  - Stimulus: data_async=0xA5, req_sync 0→1 with m_ready=1.
  - Response: after next edge ack=1, m_valid=1, m_data=0xA5, xfer_cnt=1.
  - Then req_sync→0 → ack=0 the following edge; m_valid=0 one edge after the beat.
- Backpressure:
  - Stimulus: m_ready=0, first word 0x11 accepted, then a second req_sync=1 with data 0x22.
  - Response: ack stays 0 and m_data stays 0x11 for 10 cycles.
  - Then m_ready=1 → same edge beat for 0x11 and accept of 0x22; m_valid stays 1 and m_data=0x22.
- Back-to-back:
  - Stimulus: 4 words 0x01..0x04 with m_ready=1 and req toggled as fast as ack allows.
  - Response: stream carries 0x01,0x02,0x03,0x04 in order, no duplicates; xfer_cnt=4.
- Data-change immunity:
  - Stimulus: change data_async to 0xFF while in WAIT_LOW.
  - Response: m_data keeps the captured value and no extra beat is produced.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while ack=1 and m_valid=1.
  - Response: immediately ack=0, m_valid=0, xfer_cnt=0.
  - Then release with req_sync=1 and data 0x5A → accepted on the next edge (m_data=0x5A, ack=1).
- Counter wrap:
  - Stimulus: CW=2, 5 transfers.
  - Response: xfer_cnt sequence 1,2,3,0,1.
